// File: rtl/osc_scan_monitor.sv
// osc_scan_monitor: scans every stimulus vector and flags loop oscillation.
// Each vector gets a settle window, an observe window and one result cycle.
module osc_scan_monitor #(
    parameter int VEC_W   = 8,
    parameter int NODE_W  = 3,
    parameter int SETTLE  = 4,
    parameter int OBSERVE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NODE_W-1:0] node_in,
    output logic [VEC_W-1:0]  vec_out,
    output logic              busy,
    output logic              done,
    output logic              osc_found,
    output logic [VEC_W-1:0]  osc_vec,
    output logic [NODE_W-1:0] osc_mask,
    output logic [VEC_W:0]    osc_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_OBSERVE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]       OBS_LAST    = 8'(OBSERVE - 1);
    localparam logic [VEC_W-1:0] VEC_MAX     = '1;
    localparam logic [VEC_W:0]   COUNT_ONE   = (VEC_W + 1)'(1);

    state_t            state;
    logic [7:0]        cnt;
    logic [NODE_W-1:0] node_meta;
    logic [NODE_W-1:0] node_s;
    logic [NODE_W-1:0] node_prev;
    logic [NODE_W-1:0] tog_mask;

    // Two-flop synchronizer for the asynchronous loop nodes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            node_meta <= '0;
            node_s    <= '0;
        end else begin
            node_meta <= node_in;
            node_s    <= node_meta;
        end
    end

    // Scan sequencer with registered outputs and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            vec_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            osc_found <= 1'b0;
            osc_vec   <= '0;
            osc_mask  <= '0;
            osc_count <= '0;
            node_prev <= '0;
            tog_mask  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        osc_found <= 1'b0;
                        osc_vec   <= '0;
                        osc_mask  <= '0;
                        osc_count <= '0;
                        vec_out   <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_OBSERVE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_OBSERVE: begin
                    // First cycle only takes the reference level, so a
                    // level change carried over from the last vector
                    // never counts as a toggle.
                    if (cnt == 8'd0) begin
                        tog_mask <= '0;
                    end else begin
                        tog_mask <= tog_mask | (node_s ^ node_prev);
                    end
                    node_prev <= node_s;
                    if (cnt == OBS_LAST) begin
                        cnt   <= '0;
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (tog_mask != '0) begin
                        osc_count <= osc_count + COUNT_ONE;
                        if (!osc_found) begin
                            osc_found <= 1'b1;
                            osc_vec   <= vec_out;
                            osc_mask  <= tog_mask;
                        end
                    end
                    if (vec_out == VEC_MAX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        vec_out <= vec_out + 1'b1;
                        state   <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
